// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Captures the winner's byte, strobes the UART, and supervises start timeout.
module uart_tx_arbiter #(
   parameter int N_REQ         = 4,
   parameter int START_TIMEOUT = 1023
) (
   input  logic               masterClock,
   input  logic               reset,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] reqData,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   output logic [7:0]         uartTxData,
   output logic               uartTxRequest,
   input  logic               uartTxActive,
   output logic               busy,
   input  logic               clearError,
   output logic               timeoutError
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(START_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_START,
      WAIT_DONE
   } state_t;

   state_t             state;
   state_t             stateNext;
   logic [IDX_W-1:0]   lastGrant;
   logic [IDX_W-1:0]   lastGrantNext;
   logic [CNT_W-1:0]   timeoutCnt;
   logic [CNT_W-1:0]   cntNext;
   logic [N_REQ-1:0]   grantNext;
   logic [N_REQ-1:0]   ackNext;
   logic               strobeNext;
   logic [7:0]         dataNext;
   logic               errNext;
   logic               errSet;

   logic               winFound;
   logic [IDX_W-1:0]   winIdx;
   logic [N_REQ-1:0]   winOneHot;
   logic [7:0]         winData;

   assign busy = (state != IDLE);

   // Round-robin pick: first requester after lastGrant, wrapping around
   always_comb begin
      winFound  = 1'b0;
      winIdx    = '0;
      winOneHot = '0;
      winData   = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         for (int i = 0; i < N_REQ; i++) begin
            if (!winFound && req[i] &&
                i == (int'(lastGrant) + k) % N_REQ) begin
               winFound     = 1'b1;
               winIdx       = IDX_W'(i);
               winOneHot[i] = 1'b1;
               winData      = reqData[8*i +: 8];
            end
         end
      end
   end

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      stateNext     = state;
      lastGrantNext = lastGrant;
      cntNext       = timeoutCnt;
      grantNext     = grant;
      ackNext       = '0;
      strobeNext    = 1'b0;
      dataNext      = uartTxData;
      errSet        = 1'b0;
      unique case (state)
         IDLE: begin
            if (winFound && !uartTxActive) begin
               stateNext     = ISSUE;
               grantNext     = winOneHot;
               ackNext       = winOneHot;
               dataNext      = winData;
               lastGrantNext = winIdx;
               strobeNext    = 1'b1;
            end
         end
         ISSUE: begin
            cntNext   = '0;
            stateNext = WAIT_START;
         end
         WAIT_START: begin
            if (uartTxActive) begin
               stateNext = WAIT_DONE;
            end else if (timeoutCnt == CNT_LAST) begin
               errSet    = 1'b1;
               grantNext = '0;
               cntNext   = CNT_MAX;
               stateNext = IDLE;
            end else if (timeoutCnt != CNT_MAX) begin
               cntNext = timeoutCnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!uartTxActive) begin
               grantNext = '0;
               stateNext = IDLE;
            end
         end
         default: begin
            grantNext = '0;
            stateNext = IDLE;
         end
      endcase
      if (errSet) begin
         errNext = 1'b1;
      end else if (clearError) begin
         errNext = 1'b0;
      end else begin
         errNext = timeoutError;
      end
   end

   // State and output registers with synchronous reset
   always_ff @(posedge masterClock) begin
      if (reset) begin
         state         <= IDLE;
         lastGrant     <= IDX_LAST;
         timeoutCnt    <= '0;
         grant         <= '0;
         ack           <= '0;
         uartTxRequest <= 1'b0;
         uartTxData    <= 8'h00;
         timeoutError  <= 1'b0;
      end else begin
         state         <= stateNext;
         lastGrant     <= lastGrantNext;
         timeoutCnt    <= cntNext;
         grant         <= grantNext;
         ack           <= ackNext;
         uartTxRequest <= strobeNext;
         uartTxData    <= dataNext;
         timeoutError  <= errNext;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level reference model.
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int TO = 15;

   logic            masterClock = 1'b0;
   logic            reset;
   logic [NR-1:0]   req;
   logic [8*NR-1:0] reqData;
   logic [NR-1:0]   ack;
   logic [NR-1:0]   grant;
   logic [7:0]      uartTxData;
   logic            uartTxRequest;
   logic            uartTxActive;
   logic            busy;
   logic            clearError;
   logic            timeoutError;

   always #5 masterClock = ~masterClock;

   uart_tx_arbiter #(
      .N_REQ(NR),
      .START_TIMEOUT(TO)
   ) dut (
      .masterClock(masterClock),
      .reset(reset),
      .req(req),
      .reqData(reqData),
      .ack(ack),
      .grant(grant),
      .uartTxData(uartTxData),
      .uartTxRequest(uartTxRequest),
      .uartTxActive(uartTxActive),
      .busy(busy),
      .clearError(clearError),
      .timeoutError(timeoutError)
   );

   int checks = 0;
   int failures = 0;

   task automatic checkEq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Reference model: one transfer at a time, tracked by cycles since strobe
   bit            mBusy = 0;
   bit            mStarted = 0;
   int            mSince = 0;
   int            mLast = NR - 1;
   logic [NR-1:0] expAck;
   logic [NR-1:0] expGrant;
   logic [7:0]    expData;
   logic          expStrobe;
   logic          expErr;

   function automatic int rrPick(input logic [NR-1:0] r, input int last);
      for (int k = 1; k <= NR; k++)
         if (r[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   task automatic modelEdge();
      int win;
      bit timedOut;
      expAck = '0;
      expStrobe = 1'b0;
      timedOut = 0;
      if (reset) begin
         mBusy = 0; mStarted = 0; mSince = 0; mLast = NR - 1;
         expGrant = '0; expData = 8'h00; expErr = 1'b0;
      end else begin
         if (!mBusy) begin
            if (req != 0 && !uartTxActive) begin
               win = rrPick(req, mLast);
               mLast = win;
               expAck = NR'(1) << win;
               expGrant = NR'(1) << win;
               expStrobe = 1'b1;
               expData = reqData[8*win +: 8];
               mBusy = 1; mSince = 0; mStarted = 0;
            end
         end else if (mSince == 0) begin
            mSince = 1;
         end else if (mStarted) begin
            if (!uartTxActive) begin
               mBusy = 0; expGrant = '0;
            end
         end else if (uartTxActive) begin
            mStarted = 1;
         end else if (mSince == TO) begin
            timedOut = 1; mBusy = 0; expGrant = '0;
         end else begin
            mSince++;
         end
         if (timedOut) expErr = 1'b1;
         else if (clearError) expErr = 1'b0;
      end
   endtask

   // UART behaviour: delay after strobe, then active for a hold time
   int uDelay = -1;
   int uHold = 0;
   int uForeign = 0;
   int fixDelay = -1;
   int fixHold = -1;
   bit randMode = 0;
   bit autoDrop = 1;

   task automatic uartModel();
      int d, h;
      if (expStrobe) begin
         if (fixDelay == -2) d = -1;
         else if (fixDelay >= 0) d = fixDelay;
         else if ($urandom_range(0, 4) == 0) d = -1;
         else d = int'($urandom_range(0, 20));
         h = (fixHold > 0) ? fixHold : int'($urandom_range(1, 30));
         uDelay = d;
         uHold = (d < 0) ? 0 : h;
      end
      if (uDelay > 0) begin
         uDelay--;
         uartTxActive = 1'b0;
      end else if (uDelay == 0 && uHold > 0) begin
         uartTxActive = 1'b1;
         uHold--;
         if (uHold == 0) uDelay = -1;
      end else if (uForeign > 0) begin
         uartTxActive = 1'b1;
         uForeign--;
      end else begin
         uartTxActive = 1'b0;
         if (randMode && !mBusy && $urandom_range(0, 39) == 0)
            uForeign = int'($urandom_range(1, 4));
      end
   endtask

   int nAck[NR];
   int nStrobe = 0;
   int ackOrder[$];
   logic [7:0] ackData;

   task automatic clearStats();
      for (int i = 0; i < NR; i++) nAck[i] = 0;
      nStrobe = 0;
      ackOrder.delete();
   endtask

   task automatic randomDrive();
      for (int i = 0; i < NR; i++) begin
         if (!req[i]) begin
            if ($urandom_range(0, 5) == 0) begin
               req[i] = 1'b1;
               reqData[8*i +: 8] = 8'($urandom_range(0, 255));
            end
         end else if (expAck[i]) begin
            if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
            else reqData[8*i +: 8] = 8'($urandom_range(0, 255));
         end else if ($urandom_range(0, 59) == 0) begin
            req[i] = 1'b0;
         end
      end
      clearError = ($urandom_range(0, 24) == 0);
   endtask

   task automatic cycle();
      modelEdge();
      @(posedge masterClock);
      #1;
      checkEq("ack", ack, expAck);
      checkEq("grant", grant, expGrant);
      checkEq("strobe", uartTxRequest, expStrobe);
      checkEq("data", uartTxData, expData);
      checkEq("busy", busy, mBusy);
      checkEq("err", timeoutError, expErr);
      checkEq("ackOneHot", $countones(ack) <= 1, 1);
      for (int i = 0; i < NR; i++) begin
         if (ack[i]) begin
            nAck[i]++;
            ackOrder.push_back(i);
            ackData = uartTxData;
         end
      end
      if (uartTxRequest) nStrobe++;
      uartModel();
      if (autoDrop) req = req & ~expAck;
      if (randMode) randomDrive();
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic waitIdle(input int limit, input string tag);
      int n = 0;
      while (mBusy && n < limit) begin
         cycle();
         n++;
      end
      checkEq(tag, busy, 0);
   endtask

   task automatic waitAck(input int idx, input int limit, input string tag);
      int n = 0;
      int start = nAck[idx];
      while (nAck[idx] == start && n < limit) begin
         cycle();
         n++;
      end
      checkEq(tag, nAck[idx] - start, 1);
   endtask

   task automatic uartIdle();
      uDelay = -1; uHold = 0; uForeign = 0;
      uartTxActive = 1'b0;
   endtask

   task automatic doReset();
      reset = 1'b1;
      uartIdle();
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      int fairExp[5] = '{0, 1, 2, 3, 0};
      req = '0;
      reqData = '0;
      uartTxActive = 1'b0;
      clearError = 1'b0;
      reset = 1'b1;
      clearStats();
      runCycles(3);
      checkEq("rstGrant", grant, 0);
      checkEq("rstAck", ack, 0);
      checkEq("rstStrobe", uartTxRequest, 0);
      checkEq("rstData", uartTxData, 0);
      checkEq("rstBusy", busy, 0);
      checkEq("rstErr", timeoutError, 0);
      reset = 1'b0;
      cycle();

      // single request
      clearStats();
      fixDelay = 39; fixHold = 400;
      reqData[7:0] = 8'hA5;
      req = 4'b0001;
      cycle();
      waitIdle(600, "singleIdle");
      runCycles(2);
      checkEq("singleAck", nAck[0], 1);
      checkEq("singleStrobe", nStrobe, 1);
      checkEq("singleData", ackData, 8'hA5);

      // fairness with all requests held
      doReset();
      clearStats();
      autoDrop = 0;
      fixDelay = 2; fixHold = 5;
      req = 4'b1111;
      n = 0;
      while (ackOrder.size() < 5 && n < 400) begin
         cycle();
         n++;
      end
      req = '0;
      autoDrop = 1;
      waitIdle(100, "fairIdle");
      checkEq("fairCount", ackOrder.size() >= 5, 1);
      for (int k = 0; k < 5 && k < ackOrder.size(); k++)
         checkEq($sformatf("fairOrder%0d", k), ackOrder[k], fairExp[k]);

      // start timeout
      clearStats();
      fixDelay = -2;
      reqData[7:0] = 8'h11;
      req = 4'b0001;
      n = 0;
      while (nStrobe == 0 && n < 10) begin
         cycle();
         n++;
      end
      n = 0;
      do begin
         cycle();
         n++;
      end while (!timeoutError && n < 40);
      checkEq("toLatency", n, TO + 1);
      checkEq("toGrant", grant, 0);
      checkEq("toBusy", busy, 0);
      clearError = 1'b1;
      cycle();
      clearError = 1'b0;
      checkEq("toCleared", timeoutError, 0);
      fixDelay = 3; fixHold = 5;
      reqData[15:8] = 8'h22;
      req = 4'b0010;
      waitAck(1, 20, "toNextAck");
      checkEq("toNextData", ackData, 8'h22);
      waitIdle(100, "toNextIdle");

      // captured data stays put while reqData changes
      clearStats();
      fixDelay = 5; fixHold = 20;
      reqData[7:0] = 8'h3C;
      req = 4'b0001;
      waitAck(0, 20, "stabAck");
      reqData[7:0] = 8'hFF;
      n = 0;
      while (mBusy && n < 100) begin
         cycle();
         checkEq("stabData", uartTxData, 8'h3C);
         n++;
      end

      // withdrawal of a short request while busy
      clearStats();
      fixDelay = 2; fixHold = 30;
      reqData[7:0] = 8'h55;
      req = 4'b0001;
      waitAck(0, 20, "wdAck0");
      runCycles(10);
      reqData[15:8] = 8'h77;
      req[1] = 1'b1;
      cycle();
      req[1] = 1'b0;
      waitIdle(100, "wdIdle");
      runCycles(3);
      checkEq("wdNoAck1", nAck[1], 0);
      checkEq("wdStrobes", nStrobe, 1);

      // reset during WAIT_DONE
      clearStats();
      fixDelay = 2; fixHold = 100;
      reqData[7:0] = 8'h66;
      req = 4'b0001;
      waitAck(0, 20, "rmAck0");
      n = 0;
      while (!mStarted && n < 20) begin
         cycle();
         n++;
      end
      runCycles(5);
      reset = 1'b1;
      uartIdle();
      cycle();
      checkEq("rmGrant", grant, 0);
      checkEq("rmAck", ack, 0);
      checkEq("rmStrobe", uartTxRequest, 0);
      checkEq("rmData", uartTxData, 0);
      checkEq("rmBusy", busy, 0);
      checkEq("rmErr", timeoutError, 0);
      reset = 1'b0;
      fixHold = 5;
      reqData[23:16] = 8'h99;
      req = 4'b0100;
      waitAck(2, 20, "rmAck2");
      checkEq("rmGrant2", grant, 4'b0100);
      waitIdle(100, "rmIdle");

      // random traffic
      doReset();
      clearStats();
      randMode = 1;
      autoDrop = 0;
      fixDelay = -1; fixHold = -1;
      runCycles(3000);
      randMode = 0;
      autoDrop = 1;
      req = '0;
      clearError = 1'b0;
      waitIdle(200, "randIdle");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter START_TIMEOUT, default 1023, SHALL set the maximum masterClock cycles to wait for uartTxActive to rise after issue.
REQ-003 masterClock  in  1  SHALL be the single clock; all logic on its rising edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 req  in  N_REQ  SHALL carry a per-requester transmit request; bit i held high until ack[i].
REQ-006 reqData  in  8*N_REQ  SHALL carry the byte of requester i in bits [8i+7:8i], stable while req[i] is high.
REQ-007 ack  out  N_REQ  SHALL carry a one-cycle pulse telling requester i that its byte was captured.
REQ-008 grant  out  N_REQ  SHALL be one-hot for the requester owning the transmitter, zero when idle.
REQ-009 uartTxData  out  8  SHALL carry the captured byte to the UART txData.
REQ-010 uartTxRequest  out  1  SHALL be the transmit strobe to the UART txRequest.
REQ-011 uartTxActive  in  1  SHALL be the UART txActive status.
REQ-012 busy  out  1  SHALL be high in any state other than IDLE.
REQ-013 clearError  in  1  SHALL clear timeoutError when high.
REQ-014 timeoutError  out  1  SHALL be a sticky flag indicating a start timeout.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-016 IDLE, with any req bit high and uartTxActive low: select winner, latch its reqData into uartTxData, set grant, pulse ack[winner] for one cycle, go to ISSUE.
REQ-017 IDLE with uartTxActive high (foreign or stale transfer) SHALL not grant; remain IDLE.
REQ-018 Arbitration SHALL be round-robin: search starts at lastGrant+1 modulo N_REQ; winner becomes lastGrant.
REQ-019 ISSUE SHALL drive uartTxRequest high for exactly one cycle, clear the timeout counter and go to WAIT_START.
REQ-020 WAIT_START: uartTxActive high SHALL go to WAIT_DONE.
REQ-021 WAIT_START: otherwise the counter increments; when the counter equals START_TIMEOUT, set timeoutError, clear grant and go to IDLE.
REQ-022 The timeout counter width SHALL be clog2(START_TIMEOUT+1) and SHALL saturate, never wrap.
REQ-023 WAIT_DONE: uartTxActive low SHALL clear grant and go to IDLE; the next grant is earliest the following cycle.
REQ-024 uartTxData SHALL hold its captured value from ack through return to IDLE, unaffected by reqData changes.
REQ-025 A req bit deasserted before ack SHALL be treated as withdrawn, with no ack issued.
REQ-026 req[i] still high the cycle after ack[i] SHALL be a new request, arbitrated normally.
REQ-027 When clearError and the timeout set condition coincide, set SHALL win.
REQ-028 ack, grant and uartTxRequest SHALL be registered outputs with no combinational path from req.
REQ-029 At most one ack bit SHALL be high in any cycle.

Reset
REQ-030 When reset is high at a clock edge, FSM = IDLE, grant = 0, ack = 0, uartTxRequest = 0, uartTxData = 8'h00, busy = 0, timeoutError = 0, counter = 0, lastGrant = N_REQ-1, so requester 0 has first priority.
REQ-031 Reset asserted in any state, including mid-transfer, SHALL take effect on that edge and discard the transfer without ack or error.

Verification
REQ-032 Single request: req = 0001, reqData[7:0] = 8'hA5, UART model raises txActive 40 cycles after strobe and holds it 400 cycles -> ack[0] pulse, uartTxData = A5, one uartTxRequest pulse, busy low after txActive falls.
REQ-033 Fairness: req = 1111 held continuously, four transfers -> grant order 0,1,2,3, then 0 again, with no requester served twice in a row.
REQ-034 Timeout: START_TIMEOUT = 15, txActive never rises -> timeoutError set 15 cycles after WAIT_START entry, return to IDLE; clearError = 1 clears it; next request proceeds.
REQ-035 Data stability: reqData changed from 8'h3C to 8'hFF after ack -> uartTxData stays 3C for the whole transfer.
REQ-036 Reset mid-transfer: reset = 1 during WAIT_DONE -> the next edge shows all outputs at reset values; after release with req = 0100, requester 2 is granted.
REQ-037 Withdrawal: req[1] pulsed for one cycle while busy -> no ack[1] and no transfer issued.
